// File: rtl/spy_host.sv
// rtl/spy_host.sv - spy protocol host initiator: command encoder, 8N1 UART TX/RX, reply decoder
// Optional read-reply timeout is built in when SPY_HOST_TIMEOUT_EN is defined.
module spy_host #(
  parameter int unsigned CLK_DIV = 217,
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        rs232_txd,
  input  logic        rs232_rxd
);

  localparam int unsigned   DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_NIB0, S_NIB1, S_NIB2, S_NIB3, S_OP, S_WAIT_RX, S_DONE
  } state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- UART transmitter ----------------
  logic             tx_busy_q;
  logic [9:0]       tx_sh_q;
  logic [3:0]       tx_bit_q;
  logic [DIV_W-1:0] tx_div_q;
  logic             tx_load;
  logic [7:0]       tx_byte;
  logic             tx_done;

  // Last cycle of the stop bit; a load in this cycle chains the next byte with no idle gap.
  assign tx_done   = tx_busy_q && (tx_bit_q == 4'd9) && (tx_div_q == DIV_LAST);
  assign rs232_txd = tx_busy_q ? tx_sh_q[0] : 1'b1;

  // Shift out start, 8 data bits LSB first, stop; a load always wins over the running byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_busy_q <= 1'b0;
      tx_sh_q   <= '1;
      tx_bit_q  <= '0;
      tx_div_q  <= '0;
    end else if (tx_load) begin
      tx_busy_q <= 1'b1;
      tx_sh_q   <= {1'b1, tx_byte, 1'b0};
      tx_bit_q  <= '0;
      tx_div_q  <= '0;
    end else if (tx_busy_q) begin
      if (tx_div_q == DIV_LAST) begin
        tx_div_q <= '0;
        tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
        tx_bit_q <= tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
      end else begin
        tx_div_q <= tx_div_q + 1'b1;
      end
    end
  end

  // ---------------- UART receiver ----------------
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        rx_st_q, rx_st_d;
  logic [DIV_W-1:0] rx_div_q, rx_div_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_ferr_q, rx_ferr_d;
  logic             rx_en;

  state_t state_q, state_d;
  assign rx_en = (state_q == S_WAIT_RX);

  // RX next state: confirm start at half bit, then sample each bit mid-way; held idle unless enabled.
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    rx_ferr_d  = rx_ferr_q;
    if (!rx_en) begin
      rx_st_d = RX_IDLE;
    end else begin
      case (rx_st_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_st_d  = RX_START;
            rx_div_d = '0;
          end
        end
        RX_START: begin
          if (rx_div_q == DIV_HALF) begin
            rx_div_d = '0;
            rx_bit_d = '0;
            rx_st_d  = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_div_d = rx_div_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_div_q == DIV_LAST) begin
            rx_div_d = '0;
            rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
          end else begin
            rx_div_d = rx_div_q + 1'b1;
          end
        end
        default: begin
          if (rx_div_q == DIV_LAST) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = rx_sh_q;
            rx_ferr_d  = ~rx_sync_q;
            rx_st_d    = RX_IDLE;
          end else begin
            rx_div_d = rx_div_q + 1'b1;
          end
        end
      endcase
    end
  end

  // RX registers and the two-flop line synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_div_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rs232_rxd;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_st_q    <= rx_st_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // ---------------- Command FSM ----------------
  logic [15:0] data_q, data_d;
  logic [4:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [1:0]  k_q, k_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        reply_bad;

  // A reply byte is bad on a framing error or when its tag is not 3+k.
  assign reply_bad = rx_ferr_q || (rx_byte_q[7:4] != (4'h3 + {2'b00, k_q}));

`ifdef SPY_HOST_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  // Command next state: each byte is loaded on entry to the state that transmits it.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    addr_d     = addr_q;
    write_d    = write_q;
    k_d        = k_q;
    acc_d      = acc_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    tx_load    = 1'b0;
    tx_byte    = 8'h00;
`ifdef SPY_HOST_TIMEOUT_EN
    to_d       = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          data_d  = cmd_data;
          addr_d  = cmd_addr;
          write_d = cmd_write;
          tx_load = 1'b1;
          if (cmd_write) begin
            tx_byte = {4'h3, cmd_data[3:0]};
            state_d = S_NIB0;
          end else begin
            tx_byte = {3'b100, cmd_addr};
            state_d = S_OP;
          end
        end
      end
      S_NIB0: if (tx_done) begin
        tx_load = 1'b1;
        tx_byte = {4'h4, data_q[7:4]};
        state_d = S_NIB1;
      end
      S_NIB1: if (tx_done) begin
        tx_load = 1'b1;
        tx_byte = {4'h5, data_q[11:8]};
        state_d = S_NIB2;
      end
      S_NIB2: if (tx_done) begin
        tx_load = 1'b1;
        tx_byte = {4'h6, data_q[15:12]};
        state_d = S_NIB3;
      end
      S_NIB3: if (tx_done) begin
        tx_load = 1'b1;
        tx_byte = {3'b101, addr_q};
        state_d = S_OP;
      end
      S_OP: if (tx_done) begin
        if (write_q) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = S_DONE;
        end else begin
          k_d     = '0;
          acc_d   = '0;
          state_d = S_WAIT_RX;
        end
      end
      S_WAIT_RX: begin
`ifdef SPY_HOST_TIMEOUT_EN
        to_d = to_q + 1'b1;
`endif
        if (rx_valid_q) begin
`ifdef SPY_HOST_TIMEOUT_EN
          to_d = '0;
`endif
          if (reply_bad) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = S_DONE;
          end else begin
            case (k_q)
              2'd0:    acc_d[3:0]   = rx_byte_q[3:0];
              2'd1:    acc_d[7:4]   = rx_byte_q[3:0];
              2'd2:    acc_d[11:8]  = rx_byte_q[3:0];
              default: acc_d[15:12] = rx_byte_q[3:0];
            endcase
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) begin
              rsp_data_d = {rx_byte_q[3:0], acc_q[11:0]};
              rsp_err_d  = 1'b0;
              state_d    = S_DONE;
            end
          end
        end
`ifdef SPY_HOST_TIMEOUT_EN
        else if (to_q == TO_W'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_DONE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      k_q        <= '0;
      acc_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef SPY_HOST_TIMEOUT_EN
      to_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
`ifdef SPY_HOST_TIMEOUT_EN
      to_q       <= to_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_spy_host.sv
// tb/tb_spy_host.sv - directed self-checking bench for spy_host
module tb_spy_host;
  localparam int DIV = 16;
  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        rs232_txd;
  logic        rs232_rxd;

  spy_host #(.CLK_DIV(DIV), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rs232_txd(rs232_txd), .rs232_rxd(rs232_rxd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Response monitor: counts rsp_valid pulses and latches what was seen with them.
  int          rsp_cnt = 0;
  int          rsp_cyc = 0;
  logic [15:0] rsp_d_seen = 16'h0;
  logic        rsp_e_seen = 1'b0;
  logic        rsp_rdy = 1'b0;
  logic        rsp_rdy_after = 1'b0;
  logic        prev_rsp = 1'b0;
  always @(negedge clk) begin
    if (prev_rsp) rsp_rdy_after = cmd_ready;
    prev_rsp = (rsp_valid === 1'b1);
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_cyc    = cyc;
      rsp_d_seen = rsp_data;
      rsp_e_seen = rsp_err;
      rsp_rdy    = cmd_ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int acc_cyc;
  task automatic issue(input logic wr, input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    acc_cyc = cyc;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 5'h1F; cmd_data = 16'hFFFF;
  endtask

  // Decode one byte from txd; returns at mid stop bit with the cycle the start bit was seen.
  task automatic cap_byte(output logic [7:0] b, output int t0);
    int n;
    n = 0;
    b = 8'h00;
    while (rs232_txd !== 1'b0 && n < 30 * DIV) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    chk("tx_start_seen", 32'(n < 30 * DIV), 32'd1);
    repeat (DIV / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      b[i] = rs232_txd;
    end
    repeat (DIV) @(negedge clk);
    chk("tx_stop_bit", 32'(rs232_txd), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rs232_rxd = f[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic wait_rsp(input int c0, input int limit);
    int n;
    n = 0;
    while (rsp_cnt == c0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("rsp_pulse_count", 32'(rsp_cnt - c0), 32'd1);
  endtask

  logic [7:0] b;
  int         t0, t_op, c0, n, lows;
  int         tw [0:4];
  logic [7:0] wr_exp [0:4];

  initial begin
    wr_exp = '{8'h31, 8'h42, 8'h53, 8'h64, 8'hA2};
    reset = 1'b1; rs232_rxd = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 5'h0; cmd_data = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_txd", 32'(rs232_txd), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0x02 <- 0x4321: bytes 31 42 53 64 A2, 10 bit times apart.
    c0 = rsp_cnt;
    issue(1'b1, 5'h02, 16'h4321);
    chk("wr_ready_low", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      cap_byte(b, tw[k]);
      chk("wr_byte", 32'(b), 32'(wr_exp[k]));
      if (k > 0) chk("wr_spacing", 32'(tw[k] - tw[k-1]), 32'(10 * DIV));
    end
    chk("wr_first_start", 32'((tw[0] - acc_cyc) <= 2), 32'd1);
    wait_rsp(c0, 4 * DIV);
    chk("wr_rsp_err", 32'(rsp_e_seen), 32'd0);
    chk("wr_rsp_data", 32'(rsp_d_seen), 32'd0);

    // Read 0x12, reply 32 41 50 68 -> 0x8012.
    c0 = rsp_cnt;
    issue(1'b0, 5'h12, 16'h0);
    cap_byte(b, t0);
    chk("rd12_op", 32'(b), 32'h92);
    repeat (DIV) @(negedge clk);
    chk("rd12_ready_low", 32'(cmd_ready), 32'd0);
    send_byte(8'h32); send_byte(8'h41); send_byte(8'h50); send_byte(8'h68);
    wait_rsp(c0, 4 * DIV);
    chk("rd12_data", 32'(rsp_d_seen), 32'h8012);
    chk("rd12_err", 32'(rsp_e_seen), 32'd0);
    chk("rd12_ready_at_rsp", 32'(rsp_rdy), 32'd0);
    chk("rd12_ready_after", 32'(rsp_rdy_after), 32'd1);

    // Read 0x01 with a mis-tagged second byte.
    c0 = rsp_cnt;
    issue(1'b0, 5'h01, 16'h0);
    cap_byte(b, t0);
    chk("rd01_op", 32'(b), 32'h81);
    repeat (DIV) @(negedge clk);
    send_byte(8'h35); send_byte(8'h71);
    wait_rsp(c0, 4 * DIV);
    chk("rd01_err", 32'(rsp_e_seen), 32'd1);
    chk("rd01_data", 32'(rsp_d_seen), 32'd0);

    // Following read works normally.
    c0 = rsp_cnt;
    issue(1'b0, 5'h05, 16'h0);
    cap_byte(b, t0);
    chk("rd05_op", 32'(b), 32'h85);
    repeat (DIV) @(negedge clk);
    send_byte(8'h3F); send_byte(8'h4E); send_byte(8'h5D); send_byte(8'h6C);
    wait_rsp(c0, 4 * DIV);
    chk("rd05_data", 32'(rsp_d_seen), 32'hCDEF);
    chk("rd05_err", 32'(rsp_e_seen), 32'd0);

    // Reset during data bit 2 of byte 0x53.
    c0 = rsp_cnt;
    issue(1'b1, 5'h08, 16'h0321);
    cap_byte(b, t0);
    chk("rst_wr_b0", 32'(b), 32'h31);
    cap_byte(b, t0);
    chk("rst_wr_b1", 32'(b), 32'h42);
    n = 0;
    while (rs232_txd !== 1'b0 && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    chk("rst_b2_start_seen", 32'(n < 4 * DIV), 32'd1);
    repeat (3 * DIV + DIV / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_txd", 32'(rs232_txd), 32'd1);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_no_rsp", 32'(rsp_cnt - c0), 32'd0);

    // Read 0x00 sends exactly one byte 0x80, then waits for a reply.
    c0 = rsp_cnt;
    issue(1'b0, 5'h00, 16'h0);
    cap_byte(b, t_op);
    chk("rd00_op", 32'(b), 32'h80);
    lows = 0;
    repeat (3 * DIV) begin
      @(negedge clk);
      if (rs232_txd !== 1'b1) lows++;
    end
    chk("rd00_no_extra_tx", 32'(lows), 32'd0);
`ifdef SPY_HOST_TIMEOUT_EN
    wait_rsp(c0, 2 * TMO);
    chk("tmo_err", 32'(rsp_e_seen), 32'd1);
    chk("tmo_data", 32'(rsp_d_seen), 32'd0);
    n = rsp_cyc - (t_op + 10 * DIV);
    chk("tmo_latency", 32'(n >= TMO - 2 && n <= TMO + 2), 32'd1);
    c0 = rsp_cnt;
    issue(1'b0, 5'h03, 16'h0);
    cap_byte(b, t0);
    chk("rd03_op", 32'(b), 32'h83);
    repeat (DIV) @(negedge clk);
`else
    repeat (10000) @(negedge clk);
    chk("no_tmo_still_waiting", 32'(rsp_cnt - c0), 32'd0);
    chk("no_tmo_ready_low", 32'(cmd_ready), 32'd0);
`endif

    // Short rxd glitch, then a valid all-zero reply.
    rs232_rxd = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rs232_rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    chk("glitch_no_rsp", 32'(rsp_cnt - c0), 32'd0);
    send_byte(8'h30); send_byte(8'h40); send_byte(8'h50); send_byte(8'h60);
    wait_rsp(c0, 4 * DIV);
    chk("glitch_data", 32'(rsp_d_seen), 32'h0000);
    chk("glitch_err", 32'(rsp_e_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spy_host.md
Name: spy_host

Overview:
- Host-side initiator for the spy serial protocol: the other end of the RS-232 link from spy_port.
- Accepts parallel read/write commands for 5-bit spy registers and encodes them into protocol bytes on an internal 8N1 UART transmitter.
- For reads, decodes the 4-byte nibble reply from the internal UART receiver and returns 16-bit data.
- Used as an FPGA-resident debug master and as the bus-functional host in spy benches.

Parameters:
- CLK_DIV, 217, clk cycles per serial bit (25 MHz / 115200); minimum legal value 4.
- TIMEOUT, 2000000, clk cycles to wait for a complete read reply before flagging an error (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when idle; a command is accepted on a clk edge with cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  5  spy register address (eadr).
- cmd_data  in  16  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse when a command completes.
- rsp_data  out  16  read data; 0 after a write; held until the next rsp_valid.
- rsp_err  out  1  qualified by rsp_valid: malformed reply byte, or timeout.
- rs232_txd  out  1  serial out; idles high.
- rs232_rxd  in  1  serial in; double-flop synchronised internally.

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, rs232_txd=1; all FSMs go to IDLE; any in-progress byte is abandoned. Reset mid-byte returns txd high on the next edge.
- Byte encoding:
  - Load nibble k (k = 0..3): {4'h3+k, data[4k+3:4k]}, sent least-significant nibble first. Example: 0x4321 is sent as 31 42 53 64.
  - Read: {3'b100, addr}. Write: {3'b101, addr}. Examples: read 0x02 = 0x82; write 0x08 = 0xA8.
- Command FSM states: IDLE, SEND_NIB0..SEND_NIB3, SEND_OP, WAIT_RX, DONE.
  - Write path: IDLE -> NIB0 -> NIB1 -> NIB2 -> NIB3 -> OP -> DONE.
  - Read path: IDLE -> OP -> WAIT_RX -> DONE.
  - Each SEND state loads one byte into the TX and waits for the TX to go idle after the stop bit.
  - DONE lasts 1 cycle, asserts rsp_valid, then returns to IDLE. cmd_ready rises in that same IDLE cycle.
  - cmd_addr and cmd_data are captured at accept. cmd_* inputs are don't-care while busy.
- UART TX:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit is exactly CLK_DIV cycles.
  - Back-to-back bytes carry no extra idle beyond the stop bit.
  - The first start bit begins ≤2 cycles after accept.
- UART RX:
  - Detects a falling edge and samples at CLK_DIV/2 to confirm the start bit; a false start (line high again) returns RX to idle.
  - Data bits are sampled at mid-bit.
  - A stop bit sampled low is a framing error: reply is bad, rsp_err=1.
  - RX is enabled only in WAIT_RX; bytes arriving in other states are discarded.
- Reply decode in WAIT_RX:
  - Expects 4 bytes {4'h3+k, nib_k}, k = 0..3 in order; assembled as rsp_data = {nib3, nib2, nib1, nib0}.
  - A byte whose upper nibble mismatches the expected k ends the command immediately: rsp_err=1, rsp_data=0.
- rsp_err=0 for a successful write or a successful read.

Optional Feature:
- Macro SPY_HOST_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT_RX and on each received byte. Reaching TIMEOUT moves the FSM to DONE with rsp_err=1 and rsp_data=0.
- Undefined: WAIT_RX waits indefinitely; only reset exits. No counter logic is present.

Test Plan:
- Write addr 0x02 data 0x4321 -> txd carries bytes 31 42 53 64 A2, 10×CLK_DIV cycles per byte; one rsp_valid with rsp_err=0, rsp_data=0.
- Read addr 0x12; bench replies 32 41 50 68 -> txd byte 0x92; rsp_data=0x8012, rsp_err=0; cmd_ready low from accept until the rsp_valid cycle.
- Read addr 0x01; reply second byte 0x71 instead of 0x4n -> rsp_valid after that byte with rsp_err=1, rsp_data=0; the next command is accepted normally.
- Assert reset during the 3rd bit of byte 0x53 of a write -> txd=1 and cmd_ready=1 on the next edge; a new read of 0x00 then sends exactly 0x80.
- With SPY_HOST_TIMEOUT_EN and TIMEOUT=1000: read with no reply -> rsp_valid, rsp_err=1 at 1000±2 cycles after the stop bit of the read byte. Without the macro: still waiting at 10000 cycles.
- Glitch rxd low for CLK_DIV/4 during WAIT_RX, then a valid reply 30 40 50 60 -> glitch ignored; rsp_data=0x0000, rsp_err=0.
